// File: rtl/bf_pkg.sv
// Shared types and defaults for the bound flasher controller.
// State enum and default lamp-count / kickback-index constants.
package bf_pkg;

    localparam int BF_LED_NUM = 16;
    localparam int BF_KICK_LO = 5;
    localparam int BF_KICK_HI = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP16 = 3'd1,
        ST_DN5  = 3'd2,
        ST_UP11 = 3'd3,
        ST_DN0  = 3'd4,
        ST_UP6  = 3'd5,
        ST_DN0E = 3'd6,
        ST_KDN0 = 3'd7
    } bf_state_e;

endpackage

// File: rtl/bf_therm_decode.sv
// Level to thermometer decoder for the bound flasher.
// Lamp i is lit when i is below the current level.
module bf_therm_decode #(
    parameter int LED_NUM = 16,
    parameter int LW      = 5
) (
    input  logic [LW-1:0]      lvl,
    output logic [LED_NUM-1:0] therm
);

    // one comparator per lamp
    always_comb begin
        therm = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            therm[i] = (i < int'(lvl));
        end
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher lamp sequencer driven by a one-cycle tick strobe.
// Kickback behaviour is built only with BOUND_FLASHER_KICKBACK_EN.
module bound_flasher_ctrl
    import bf_pkg::*;
#(
    parameter int LED_NUM = BF_LED_NUM,
    parameter int KICK_LO = BF_KICK_LO,
    parameter int KICK_HI = BF_KICK_HI
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               flick,
    output logic [LED_NUM-1:0] lamp,
    output logic               busy
);

    localparam int LW = $clog2(LED_NUM + 1);

    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO = '0;
    localparam logic [LW-1:0] LVL_TOP  = LW'(LED_NUM);
    localparam logic [LW-1:0] LVL_LO   = LW'(KICK_LO);
    localparam logic [LW-1:0] LVL_LO1  = LW'(KICK_LO + 1);
    localparam logic [LW-1:0] LVL_HI1  = LW'(KICK_HI + 1);

    bf_state_e            state_q, state_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic [LED_NUM-1:0]   lamp_q, lamp_d;
    logic                 busy_q, busy_d;
    logic [LW-1:0]        lvl_up, lvl_dn;

    assign lvl_up = lvl_q + LVL_ONE;
    assign lvl_dn = lvl_q - LVL_ONE;

    // next state and level; nothing moves without a tick
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (flick) state_d = ST_UP16;
                end
                ST_UP16: begin
                    lvl_d = lvl_up;
                    if (lvl_up == LVL_TOP) begin
                        state_d = ST_DN5;
                    end
`ifdef BOUND_FLASHER_KICKBACK_EN
                    else if (flick &&
                             (lvl_up == LVL_LO1 ||
                              lvl_up == LVL_HI1)) begin
                        state_d = ST_KDN0;
                    end
`endif
                end
                ST_DN5: begin
                    lvl_d = lvl_dn;
                    if (lvl_dn == LVL_LO) state_d = ST_UP11;
                end
                ST_UP11: begin
                    lvl_d = lvl_up;
                    if (lvl_up == LVL_HI1) begin
`ifdef BOUND_FLASHER_KICKBACK_EN
                        state_d = flick ? ST_DN5 : ST_DN0;
`else
                        state_d = ST_DN0;
`endif
                    end
                end
                ST_DN0: begin
                    lvl_d = lvl_dn;
                    if (lvl_dn == LVL_ZERO) state_d = ST_UP6;
                end
                ST_UP6: begin
                    lvl_d = lvl_up;
                    if (lvl_up == LVL_LO1) state_d = ST_DN0E;
                end
                ST_DN0E: begin
                    lvl_d = lvl_dn;
                    if (lvl_dn == LVL_ZERO) state_d = ST_IDLE;
                end
`ifdef BOUND_FLASHER_KICKBACK_EN
                ST_KDN0: begin
                    lvl_d = lvl_dn;
                    if (lvl_dn == LVL_ZERO) state_d = ST_UP16;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    lvl_d   = LVL_ZERO;
                end
            endcase
        end
    end

    bf_therm_decode #(
        .LED_NUM (LED_NUM),
        .LW      (LW)
    ) u_therm (
        .lvl   (lvl_d),
        .therm (lamp_d)
    );

    assign busy_d = (state_d != ST_IDLE);

    // registered state, level and outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            lamp_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            lamp_q  <= lamp_d;
            busy_q  <= busy_d;
        end
    end

    assign lamp = lamp_q;
    assign busy = busy_q;

endmodule

// File: doc/bound_flasher_ctrl.md
BOUND_FLASHER_CTRL -- requirements
Module: bound_flasher_ctrl

Interface
REQ-001 Parameter LED_NUM, default 16: number of lamps; legal range 12 to 32.
REQ-002 Parameter KICK_LO, default 5: lower kickback lamp index and the DN5/UP6 bound.
REQ-003 Parameter KICK_HI, default 10: upper kickback lamp index and the UP11 bound; KICK_LO < KICK_HI < LED_NUM-1.
REQ-004 Port clk, input, 1 bit: system clock; the only clock used.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port tick, input, 1 bit: one-clk step strobe from the system clock generator; the block never uses a divided clock as a clock.
REQ-007 Port flick, input, 1 bit: start/kickback request; synchronous to clk; sampled only on tick cycles.
REQ-008 Port lamp, output, LED_NUM bits: lamp drive; lamp[i]=1 means lit.
REQ-009 Port busy, output, 1 bit: 1 whenever state is not IDLE.

Function
REQ-010 Internal level lvl, 0..LED_NUM; lamp[i]=1 iff i<lvl (thermometer); lamp and busy are registered.
REQ-011 States: IDLE, UP16, DN5, UP11, DN0, UP6, DN0E, KDN0 (kickback fall to 0).
REQ-012 No state or lvl change on cycles with tick=0.
REQ-013 IDLE: lvl held at 0; tick&&flick -> UP16, lvl unchanged.
REQ-014 Up states: lvl+1 per tick; down states: lvl-1 per tick; state change is registered in the same cycle lvl reaches the target.
REQ-015 Targets/exits: UP16 at lvl=LED_NUM -> DN5; DN5 at lvl=KICK_LO -> UP11; UP11 at lvl=KICK_HI+1 -> DN0; DN0 at 0 -> UP6; UP6 at lvl=KICK_LO+1 -> DN0E; DN0E at 0 -> IDLE; KDN0 at 0 -> UP16.
REQ-016 Kickback in UP16: a tick with flick=1 whose next lvl is KICK_LO+1 or KICK_HI+1 -> KDN0.
REQ-017 Kickback in UP11: a tick with flick=1 whose next lvl is KICK_HI+1 -> DN5 instead of DN0.
REQ-018 flick is ignored in every other state and at every other lvl; no kickback in DN/UP6 states.
REQ-019 lvl never leaves 0..LED_NUM; no wrap-around.

Reset
REQ-020 rst_n=0 at a clk edge: state=IDLE, lvl=0, lamp=0, busy=0 on the next cycle, regardless of tick or current state.
REQ-021 Reset mid-sequence aborts the sequence; nothing is remembered; a new start requires tick&&flick.

Configuration
REQ-022 Macro BOUND_FLASHER_KICKBACK_EN defined: REQ-016 and REQ-017 are active and state KDN0 exists.
REQ-023 Macro undefined: no kickback; KDN0 is not built; flick matters only in IDLE; UP11 always -> DN0.

Structure
REQ-024 Package bf_pkg holds the state enum bf_state_e and the default LED_NUM/KICK_LO/KICK_HI constants.
REQ-025 One sub-module, bf_therm_decode: combinational lvl -> LED_NUM-bit thermometer; its output is registered in bound_flasher_ctrl.

Verification
REQ-026 Reset, then 10 ticks with flick=0 -> lamp=0, busy=0 throughout.
REQ-027 One tick with flick=1, then flick=0 -> exactly 57 ticks to IDLE; peak lamp=16'hFFFF; lamp=16'h001F after DN5; lamp=16'h07FF at the end of UP11; lamp=16'h003F at the end of UP6.
REQ-028 With KICKBACK_EN, flick=1 on the UP16 tick that lights lamp[5] -> lamp=16'h003F then falls to 0 over 6 ticks, then rises again in UP16.
REQ-029 With KICKBACK_EN, flick=1 on the UP11 tick reaching lamp=16'h07FF -> DN5 back to 16'h001F, then UP11 repeats.
REQ-030 Without the macro, the REQ-028 stimulus -> no kickback; sequence identical to REQ-027.
REQ-031 rst_n=0 for one cycle while in DN0 with lamp=16'h00FF -> lamp=0 and busy=0 on the next cycle; no activity until tick&&flick.
